onehot_decoder_pipe: RTL and testbench

//   Registered binary-to-one-hot decoder; the receive-side counterpart of the team's 4-to-2 priority encoder.

---
 rtl/onehot_dec_pkg.sv | 20 ++
 rtl/dec_skid_buf.sv | 84 ++++++++
 rtl/onehot_decoder_pipe.sv | 92 +++++++++
 tb/tb_onehot_decoder_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot decoder pipeline.
// Provides the skid FSM state enum, the default code width and a one-hot helper.
package onehot_dec_pkg;

  localparam int DEF_IN_W  = 2;
  localparam int DEF_OUT_W = 1 << DEF_IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } dec_state_t;

  function automatic logic [DEF_OUT_W-1:0] onehot(
    input logic [DEF_IN_W-1:0] code
  );
    return {{(DEF_OUT_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; the FSM state drives out_valid and in_ready.
// Ports: clk, rst (sync, active-high), in_valid/in_data/in_ready, out_valid/out_data/out_ready.
module dec_skid_buf
  import onehot_dec_pkg::*;
#(
  parameter int W = DEF_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  dec_state_t r_state;
  dec_state_t w_state_nxt;
  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic [W-1:0] w_out_nxt;
  logic [W-1:0] w_skid_nxt;
  logic w_acc;
  logic w_dlv;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = (r_state != FULL);
  assign out_data  = r_out;

  assign w_acc = in_valid & in_ready;
  assign w_dlv = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt = BUSY;
          w_out_nxt   = in_data;
        end
      end
      BUSY: begin
        if (w_acc && w_dlv) begin
          w_out_nxt = in_data;
        end else if (w_acc) begin
          w_state_nxt = FULL;
          w_skid_nxt  = in_data;
        end else if (w_dlv) begin
          // keep out_data at zero while nothing is valid
          w_state_nxt = EMPTY;
          w_out_nxt   = '0;
        end
      end
      FULL: begin
        if (w_dlv) begin
          w_state_nxt = BUSY;
          w_out_nxt   = r_skid;
          w_skid_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_out_nxt   = '0;
        w_skid_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a delivered-word counter.
// Ports: clk, rst, in_valid/in_code/in_ready, out_valid/out_data/out_ready, dec_cnt;
// DEC_PARITY_EN adds in_parity, par_err and err_cnt (even parity over in_code).
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      in_code,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [(1<<IN_W)-1:0] out_data,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     dec_cnt
`ifdef DEC_PARITY_EN
  ,
  input  logic                 in_parity,
  output logic                 par_err,
  output logic [7:0]           err_cnt
`endif
);

  localparam int OUT_W = 1 << IN_W;

  function automatic logic [OUT_W-1:0] decode(
    input logic [IN_W-1:0] c
  );
    return {{(OUT_W-1){1'b0}}, 1'b1} << c;
  endfunction

  logic             w_push;
  logic [OUT_W-1:0] w_word;
  logic [CNT_W-1:0] r_cnt;

  assign w_word = decode(in_code);

`ifdef DEC_PARITY_EN
  logic       w_par_ok;
  logic       w_acc;
  logic       r_par_err;
  logic [7:0] r_err_cnt;

  // bad-parity codes are consumed (in_ready honoured) but never queued
  assign w_par_ok = (in_parity == ^in_code);
  assign w_acc    = in_valid & in_ready;
  assign w_push   = in_valid & w_par_ok;
  assign par_err  = r_par_err;
  assign err_cnt  = r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_par_err <= w_acc & ~w_par_ok;
      if (w_acc && !w_par_ok && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end
`else
  assign w_push = in_valid;
`endif

  dec_skid_buf #(
    .W(OUT_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_push),
    .in_data  (w_word),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign dec_cnt = r_cnt;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe: scoreboard on delivered words
// plus scenario tasks for reset, sweep, backpressure, counter wrap, mid-op reset, parity.
module tb_onehot_decoder_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [7:0] dec_cnt;

  logic       w_in_ready;
  logic       w_out_valid;
  logic [3:0] w_out_data;
  logic [1:0] w_dec_cnt;

`ifdef DEC_PARITY_EN
  logic       in_parity;
  logic       par_err;
  logic [7:0] err_cnt;
  logic       w_par_err;
  logic [7:0] w_err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] sb_q[$];
  logic [3:0] sb_exp;

  onehot_decoder_pipe #(.IN_W(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .dec_cnt  (dec_cnt)
`ifdef DEC_PARITY_EN
    ,
    .in_parity(in_parity),
    .par_err  (par_err),
    .err_cnt  (err_cnt)
`endif
  );

  onehot_decoder_pipe #(.IN_W(2), .CNT_W(2)) dut_w (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (w_in_ready),
    .out_valid(w_out_valid),
    .out_data (w_out_data),
    .out_ready(out_ready),
    .dec_cnt  (w_dec_cnt)
`ifdef DEC_PARITY_EN
    ,
    .in_parity(in_parity),
    .par_err  (w_par_err),
    .err_cnt  (w_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_word(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  function automatic logic par_ok();
`ifdef DEC_PARITY_EN
    return in_parity == ^in_code;
`else
    return 1'b1;
`endif
  endfunction

  // scoreboard: inputs are stable at the edge, DUT regs still hold pre-edge values
  always @(posedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_deliver: got %b, required no word", out_data);
        end else begin
          sb_exp = sb_q.pop_front();
          if (out_data !== sb_exp) begin
            errors++;
            $display("FAIL sb_order: got %b, required %b", out_data, sb_exp);
          end
        end
      end
      if (in_valid && in_ready && par_ok()) sb_q.push_back(exp_word(in_code));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [1:0] c);
    in_valid = v;
    in_code  = c;
`ifdef DEC_PARITY_EN
    in_parity = ^c;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(1'b0, 2'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    send(1'b1, 2'd2);
    repeat (3) tick();
    rst = 1'b0;
    send(1'b0, 2'd0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%b, required v=0 d=0000", out_valid, out_data);
    end
    checks++;
    if (dec_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cnt_rdy: got cnt=%0d rdy=%b, required cnt=0 rdy=1", dec_cnt, in_ready);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 2'(i));
      tick();
      e = exp_word(2'(i));
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep_%0d: got v=%b d=%b rdy=%b, required v=1 d=%b rdy=1",
                 i, out_valid, out_data, in_ready, e);
      end
    end
    send(1'b0, 2'd0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000 || dec_cnt !== 8'd4) begin
      errors++;
      $display("FAIL sweep_end: got v=%b d=%b cnt=%0d, required v=0 d=0000 cnt=4",
               out_valid, out_data, dec_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1'b1, 2'd2);
    tick();
    send(1'b1, 2'd3);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 4'b0100 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b d=%b, required rdy=0 v=1 d=0100",
               in_ready, out_valid, out_data);
    end
    send(1'b1, 2'd1);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 4'b0100) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b d=%b, required rdy=0 d=0100", in_ready, out_data);
    end
    send(1'b0, 2'd0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 4'b1000 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got v=%b d=%b rdy=%b, required v=1 d=1000 rdy=1",
               out_valid, out_data, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || dec_cnt !== 8'd6) begin
      errors++;
      $display("FAIL bp_end: got v=%b cnt=%0d, required v=0 cnt=6", out_valid, dec_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5];
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(i < 5, 2'(i % 4));
      tick();
      if (i > 0) begin
        checks++;
        if (w_dec_cnt !== exp_w[i-1]) begin
          errors++;
          $display("FAIL wrap_%0d: got cnt=%0d, required %0d", i, w_dec_cnt, exp_w[i-1]);
        end
      end
    end
    checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || w_out_data !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_idle: got v=%b rdy=%b d=%b, required v=0 rdy=1 d=0000",
               w_out_valid, w_in_ready, w_out_data);
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    send(1'b1, 2'd3);
    tick();
    send(1'b1, 2'd2);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: got rdy=%b, required 0", in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(1'b0, 2'd0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: got v=%b d=%b rdy=%b, required v=0 d=0000 rdy=1",
               out_valid, out_data, in_ready);
    end
    send(1'b1, 2'd1);
    tick();
    send(1'b0, 2'd0);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b0010) begin
      errors++;
      $display("FAIL mid_code: got v=%b d=%b, required v=1 d=0010", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000) begin
      errors++;
      $display("FAIL mid_stale: got v=%b d=%b, required v=0 d=0000", out_valid, out_data);
    end
  endtask

`ifdef DEC_PARITY_EN
  task automatic test_parity();
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 2'd3);
    in_parity = 1'b1;
    tick();
    send(1'b0, 2'd0);
    checks++;
    if (par_err !== 1'b1 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL par_bad: got pe=%b ec=%0d v=%b, required pe=1 ec=1 v=0",
               par_err, err_cnt, out_valid);
    end
    tick();
    checks++;
    if (par_err !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL par_pulse: got pe=%b ec=%0d, required pe=0 ec=1", par_err, err_cnt);
    end
    send(1'b1, 2'd3);
    tick();
    send(1'b0, 2'd0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1000 || par_err !== 1'b0) begin
      errors++;
      $display("FAIL par_good: got v=%b d=%b pe=%b, required v=1 d=1000 pe=0",
               out_valid, out_data, par_err);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    logic [1:0] c;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      c = 2'($urandom_range(0, 3));
      send(1'b1, c);
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_data !== exp_word(c)) begin
        errors++;
        $display("FAIL b2b_%0d: got rdy=%b d=%b, required rdy=1 d=%b",
                 i, in_ready, out_data, exp_word(c));
      end
    end
    send(1'b0, 2'd0);
    tick();
    checks++;
    if (sb_q.size() != 0 || dec_cnt !== 8'd20) begin
      errors++;
      $display("FAIL b2b_end: got q=%0d cnt=%0d, required q=0 cnt=20", sb_q.size(), dec_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    send(1'b0, 2'd0);
    test_reset();
    test_sweep();
    test_backpressure();
    test_wrap();
    test_midreset();
`ifdef DEC_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
